lsu_byte_seq: RTL
=================

// Module: lsu_byte_seq
// PURPOSE
//  Load/store initiator between the core's memory stage and the byte-wide data memory.
//  Accepts one load/store request per handshake and sequences it as 1/2/4 single-byte accesses.
//  Byte order is big-endian: MSB at the lowest address.
//  Assembles load bytes and sign- or zero-extends the result, then returns a one-cycle response.
// PARAMETERS
//  MEM_BYTES  100  data memory size in bytes; any access touching addr >= MEM_BYTES is an error
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   reset, asynchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   high only in IDLE; request accepted when req_valid && req_ready
//  req_we      in   1   1 = store, 0 = load
//  req_addr    in   32  byte address of the MSB
//  req_mode    in   3   000 BYTE, 001 HALF, 010 WORD, 011 BYTE_U, 100 HALF_U; 101-111 invalid
//  req_wdata   in   32  store data, right-justified
//  rsp_valid   out  1   one-cycle pulse marking completion; no backpressure
//  rsp_err     out  1   valid with rsp_valid: request rejected, no memory access made
//  rsp_rdata   out  32  load result, extended; 0 for stores and errors; held until next rsp
//  mem_rd_en   out  1   byte read strobe; memory read is combinational, sampled same cycle
//  mem_wr_en   out  1   byte write strobe; memory writes on posedge
//  mem_addr    out  32  byte address
//  mem_wdata   out  8   store byte
//  mem_rdata   in   8   read byte
// BEHAVIOUR
//  - Reset: all outputs 0 except req_ready = 1; state IDLE; byte counter and data register 0.
//  - Size N from mode: BYTE/BYTE_U = 1, HALF/HALF_U = 2, WORD = 4.
//    For stores, BYTE_U is treated as BYTE and HALF_U as HALF.
//  - FSM states: IDLE, ACCESS, RESP.
//  - IDLE:
//    - On accept, latch we/addr/mode/wdata.
//    - Invalid mode or (addr + N - 1) >= MEM_BYTES (33-bit compare, no wrap): go to RESP with err = 1.
//    - Otherwise go to ACCESS with k = 0.
//  - ACCESS, byte k:
//    - mem_addr = addr + k; mem_rd_en = !we; mem_wr_en = we.
//    - Store: mem_wdata = byte (N-1-k) of wdata, so the MSB goes first
//      (WORD: [31:24] at addr; HALF: [15:8] at addr; BYTE: [7:0]).
//    - Load: on posedge, data <= {data[23:0], mem_rdata}.
//    - k == N-1 leads to RESP; otherwise k <= k + 1.
//    - Strobes are never high outside ACCESS, and never both high.
//  - RESP (exactly one cycle):
//    - rsp_valid = 1; req_ready = 0; then IDLE.
//    - rsp_rdata updates on entry to RESP:
//      - BYTE: sign-extend bit 7; HALF: sign-extend bit 15.
//      - BYTE_U / HALF_U: zero-extend; WORD: as is.
//  - Latency: accept at edge T, accesses in cycles T+1..T+N, rsp_valid in cycle T+N+1.
//    Next accept no earlier than edge T+N+2.
//  - Reset mid-ACCESS: aborts immediately, outputs go to reset values, no response.
//    Store bytes already written stay in memory.
//  - req_* inputs are ignored while not in IDLE.
// CONFIGURATION
//  - LSU_MISALIGN_TRAP_EN defined: if addr % N != 0, the request goes to RESP with rsp_err = 1
//    and makes no access.
//  - Undefined: misaligned accesses are performed byte by byte like any other access.
// STRUCTURE
//  - lsu_pkg: mem_acc_mode encodings (BYTE..HALFWORD_UNSIGNED) and the lsu_state_e enum
//    {IDLE, ACCESS, RESP}.
//  - Sub-module lsu_load_ext: combinational extension of the assembled data by mode.
//  - The FSM, byte counter and data shift register stay in lsu_byte_seq.
// TESTING
//  - Pre-loaded mem[8..11] = 80 01 02 03:
//    - WORD load @8 -> rsp_rdata = 0x80010203 at T+5.
//    - HALF @8 -> 0xFFFF8001; HALF_U @8 -> 0x00008001; BYTE @8 -> 0xFFFFFF80.
//  - WORD store 0xDEADBEEF @20 -> mem_wr_en for 4 cycles; mem[20..23] = DE AD BE EF.
//    A following WORD load @20 returns 0xDEADBEEF.
//  - Invalid or out-of-range requests -> rsp_valid with rsp_err = 1 at T+1, no strobes:
//    - mode 3'b111;
//    - WORD @97 (MEM_BYTES = 100);
//    - WORD @0xFFFF_FFFE (must not wrap).
//  - Misaligned HALF store 0x1234 @5:
//    - LSU_MISALIGN_TRAP_EN defined -> err = 1, mem unchanged.
//    - Undefined -> mem[5] = 12, mem[6] = 34.
//  - Assert rst in the 2nd access cycle of a WORD store:
//    - Outputs reset at once; mem[addr] holds the written byte; mem[addr+1..] unchanged.
//    - No rsp_valid; req_ready = 1 after rst falls.
//  - Back-to-back req_valid held high -> accepts are spaced N+2 cycles apart.
//    req_ready = 0 throughout ACCESS and RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-sequencing load/store unit:
// access-mode encodings, FSM state encoding and a mode-to-size helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        MODE_BYTE               = 3'b000,
        MODE_HALFWORD           = 3'b001,
        MODE_WORD               = 3'b010,
        MODE_BYTE_UNSIGNED      = 3'b011,
        MODE_HALFWORD_UNSIGNED  = 3'b100
    } mem_acc_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Number of bytes moved by an access; 0 flags an unsupported mode.
    function automatic logic [2:0] mode_size(input logic [2:0] mode);
        logic [2:0] size;
        case (mode)
            MODE_BYTE, MODE_BYTE_UNSIGNED:         size = 3'd1;
            MODE_HALFWORD, MODE_HALFWORD_UNSIGNED: size = 3'd2;
            MODE_WORD:                             size = 3'd4;
            default:                               size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of assembled load data according to the access mode.
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [31:0] data,
    output logic [31:0] ext
);

    // Pick the extension rule for the latched access mode.
    always_comb begin
        ext = 32'h0000_0000;
        case (mode)
            MODE_BYTE:              ext = {{24{data[7]}}, data[7:0]};
            MODE_HALFWORD:          ext = {{16{data[15]}}, data[15:0]};
            MODE_WORD:              ext = data;
            MODE_BYTE_UNSIGNED:     ext = {24'h00_0000, data[7:0]};
            MODE_HALFWORD_UNSIGNED: ext = {16'h0000, data[15:0]};
            default:                ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Load/store initiator that splits 1/2/4-byte requests into single-byte
// big-endian memory accesses and returns a one-cycle response.
// Optional build macro: LSU_MISALIGN_TRAP_EN rejects addresses not aligned
// to the access size instead of performing them byte by byte.
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 100
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    lsu_state_e  state;
    logic        we;
    logic [2:0]  mode;
    logic [2:0]  size;
    logic [1:0]  k;
    // Holds pending store bytes (MSB first) or load bytes collected so far.
    logic [23:0] data;

    logic [2:0]  acc_size;
    logic [32:0] last_addr;
    logic        range_err;
    logic        mode_err;
    logic        misalign_err;
    logic        req_err;
    logic [31:0] wdata_aligned;
    logic [31:0] next_data;
    logic [31:0] ext_data;
    logic        k_last;

    // Request decode: size, range/mode/alignment checks and store byte alignment.
    always_comb begin
        acc_size  = mode_size(req_mode);
        // 33-bit sum so an address near 2^32 cannot wrap into range.
        last_addr = {1'b0, req_addr} + {30'b0, acc_size} - 33'd1;
        range_err = (last_addr >= 33'(MEM_BYTES));
        mode_err  = (acc_size == 3'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_err = ((req_addr[1:0] & (acc_size[1:0] - 2'd1)) != 2'b00);
`else
        misalign_err = 1'b0;
`endif
        req_err = mode_err || range_err || misalign_err;
        case (acc_size)
            3'd1:    wdata_aligned = {req_wdata[7:0], 24'h00_0000};
            3'd2:    wdata_aligned = {req_wdata[15:0], 16'h0000};
            default: wdata_aligned = req_wdata;
        endcase
    end

    // Byte progress and the value the load result will take after this byte.
    always_comb begin
        next_data = {data, mem_rdata};
        k_last    = ({1'b0, k} == (size - 3'd1));
    end

    lsu_load_ext u_load_ext (
        .mode (mode),
        .data (next_data),
        .ext  (ext_data)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            we        <= 1'b0;
            mode      <= 3'b000;
            size      <= 3'd0;
            k         <= 2'd0;
            data      <= 24'h00_0000;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        we        <= req_we;
                        mode      <= req_mode;
                        size      <= acc_size;
                        k         <= 2'd0;
                        if (req_err) begin
                            state     <= RESP;
                            data      <= 24'h00_0000;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0000_0000;
                        end else begin
                            state     <= ACCESS;
                            mem_addr  <= req_addr;
                            mem_rd_en <= !req_we;
                            mem_wr_en <= req_we;
                            mem_wdata <= req_we ? wdata_aligned[31:24] : 8'h00;
                            data      <= req_we ? wdata_aligned[23:0] : 24'h00_0000;
                        end
                    end
                end
                ACCESS: begin
                    data <= next_data[23:0];
                    if (k_last) begin
                        state     <= RESP;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                        mem_addr  <= 32'h0000_0000;
                        mem_wdata <= 8'h00;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= we ? 32'h0000_0000 : ext_data;
                    end else begin
                        k         <= k + 2'd1;
                        mem_addr  <= mem_addr + 32'd1;
                        mem_wdata <= we ? data[23:16] : 8'h00;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
